wb_mem_loader: RTL

// - Wishbone B4 pipelined initiator that fills program RAM from a byte stream (e.g. UART/JTAG bridge); the hardware counterpart of a bench memory preload.
// - Sits as an extra master on wb_interconnect_sharedbus, ahead of ibex_wb; holds the core in reset until the image is written.
// - Stream format: 4-byte little-endian word count N, then 4*N data bytes, each word little-endian.

---
 rtl/wb_mem_loader_if.sv | 30 +++
 rtl/wb_mem_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_mem_loader_if.sv
// Byte-stream sink plus Wishbone B4 pipelined write-master signals of the memory loader.
// master = loader side, slave = stream source / bus fabric side.
interface wb_mem_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
    input  wb_ack, wb_err, wb_stall
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
    output wb_ack, wb_err, wb_stall
  );
endinterface

// File: rtl/wb_mem_loader.sv
// wb_mem_loader: writes a length-prefixed little-endian byte stream into RAM over Wishbone, holds the core until done.
// Latency: last data byte -> wb_stb 1 cycle, wb_ack -> s_ready 1 cycle; at most one transfer in flight.
// Backpressure: s_ready low during a bus write and in DONE/ERR. Optional trailer checksum: WB_MEM_LOADER_CHECKSUM_EN.
module wb_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0001_0000
) (
  input  logic            clk,
  input  logic            rst,
  wb_mem_loader_if.master bus,
  output logic            core_hold,
  output logic            done,
  output logic            error
);
  localparam logic [31:0] MAX_WORDS = MEM_SIZE >> 2;

`ifdef WB_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, DATA, REQ, WAIT, DONE, ERR, CHK} state_t;
`else
  typedef enum logic [2:0] {HDR, DATA, REQ, WAIT, DONE, ERR} state_t;
`endif

  state_t      state;
  logic [1:0]  bcnt;
  logic [31:0] cnt;
  logic [31:0] idx;
  logic [23:0] word;
`ifdef WB_MEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  logic        take;
  logic [31:0] hdr_word;
  logic [31:0] byte_word;
  logic [31:0] idx_inc;

  // Both shift registers take bytes at the top, so byte 0 ends up in the LSBs.
  assign take      = bus.s_valid && bus.s_ready;
  assign hdr_word  = {bus.s_data, cnt[31:8]};
  assign byte_word = {bus.s_data, word};
  assign idx_inc   = idx + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HDR;
      bcnt         <= 2'd0;
      cnt          <= 32'd0;
      idx          <= 32'd0;
      word         <= 24'd0;
`ifdef WB_MEM_LOADER_CHECKSUM_EN
      sum          <= 32'd0;
`endif
      bus.s_ready  <= 1'b0;
      bus.wb_cyc   <= 1'b0;
      bus.wb_stb   <= 1'b0;
      bus.wb_we    <= 1'b0;
      bus.wb_adr   <= BASE_ADDR;
      bus.wb_sel   <= 4'h0;
      bus.wb_dat_o <= 32'd0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.s_ready <= 1'b0;
      case (state)
        HDR: begin
          bus.s_ready <= 1'b1;
          if (take) begin
            cnt  <= hdr_word;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              idx <= 32'd0;
              if (hdr_word == 32'd0) begin
`ifdef WB_MEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                bus.s_ready <= 1'b0;
                state       <= DONE;
`endif
              end else if (hdr_word > MAX_WORDS) begin
                bus.s_ready <= 1'b0;
                state       <= ERR;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          bus.s_ready <= 1'b1;
          if (take) begin
            word <= {bus.s_data, word[23:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              bus.s_ready  <= 1'b0;
              bus.wb_dat_o <= byte_word;
              bus.wb_adr   <= BASE_ADDR + {idx[29:0], 2'b00};
              bus.wb_cyc   <= 1'b1;
              bus.wb_stb   <= 1'b1;
              bus.wb_we    <= 1'b1;
              bus.wb_sel   <= 4'hF;
`ifdef WB_MEM_LOADER_CHECKSUM_EN
              sum          <= sum + byte_word;
`endif
              state        <= REQ;
            end
          end
        end

        // A response in the acceptance cycle is legal, so REQ shares WAIT's response handling.
        REQ, WAIT: begin
          if (state == REQ && !bus.wb_stall) begin
            bus.wb_stb <= 1'b0;
            bus.wb_we  <= 1'b0;
            bus.wb_sel <= 4'h0;
            state      <= WAIT;
          end
          if (state == WAIT || !bus.wb_stall) begin
            if (bus.wb_err) begin
              bus.wb_cyc <= 1'b0;
              bus.wb_stb <= 1'b0;
              bus.wb_we  <= 1'b0;
              bus.wb_sel <= 4'h0;
              state      <= ERR;
            end else if (bus.wb_ack) begin
              bus.wb_cyc <= 1'b0;
              bus.wb_stb <= 1'b0;
              bus.wb_we  <= 1'b0;
              bus.wb_sel <= 4'h0;
              idx        <= idx_inc;
              if (idx_inc == cnt) begin
`ifdef WB_MEM_LOADER_CHECKSUM_EN
                bus.s_ready <= 1'b1;
                state       <= CHK;
`else
                state       <= DONE;
`endif
              end else begin
                bus.s_ready <= 1'b1;
                state       <= DATA;
              end
            end
          end
        end

`ifdef WB_MEM_LOADER_CHECKSUM_EN
        CHK: begin
          bus.s_ready <= 1'b1;
          if (take) begin
            word <= {bus.s_data, word[23:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              bus.s_ready <= 1'b0;
              state       <= (byte_word == sum) ? DONE : ERR;
            end
          end
        end
`endif

        DONE: begin
          done      <= 1'b1;
          core_hold <= 1'b0;
        end

        ERR: begin
          error     <= 1'b1;
          core_hold <= 1'b1;
        end

        default: state <= ERR;
      endcase
    end
  end
endmodule
